// File: rtl/filter_ctrl_if.sv
// filter_ctrl_if: bundles the host register port, the config bus to the
// filter datapath, the upstream pixel stream and the datapath pixel/result
// stream used by filter_ctrl.
//   host_wr/host_addr/host_data : shadow-register write port (host -> ctrl)
//   host_start/busy/done        : frame sequencing handshake
//   cfg_data/cfg_addr/cfg_valid : config word stream (ctrl -> datapath)
//   src_data/src_val/src_rdy    : upstream pixels, valid/ready
//   img_data/img_val            : pixels forwarded to the datapath
//   res_val/res_cnt             : datapath result strobe and result count
// Modport slave is the controller side, master is the host/environment side.
interface filter_ctrl_if #(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 24
);
  logic                  host_wr;
  logic [3:0]            host_addr;
  logic [CFG_DWIDTH-1:0] host_data;
  logic                  host_start;
  logic                  busy;
  logic                  done;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic [IMG_WIDTH-1:0]  src_data;
  logic                  src_val;
  logic                  src_rdy;
  logic [IMG_WIDTH-1:0]  img_data;
  logic                  img_val;
  logic                  res_val;
  logic [LEN_WIDTH-1:0]  res_cnt;

  modport slave (
    input  host_wr, host_addr, host_data, host_start,
    input  src_data, src_val, res_val,
    output busy, done, cfg_data, cfg_addr, cfg_valid,
    output src_rdy, img_data, img_val, res_cnt
  );

  modport master (
    output host_wr, host_addr, host_data, host_start,
    output src_data, src_val, res_val,
    input  busy, done, cfg_data, cfg_addr, cfg_valid,
    input  src_rdy, img_data, img_val, res_cnt
  );
endinterface

// File: rtl/filter_ctrl.sv
// filter_ctrl: host-programmable sequencer for a 3x3 image filter datapath.
// The host fills shadow registers while idle, then pulses host_start. The
// controller pushes the configuration (line width, 9 kernel coefficients,
// rescale word) over the cfg bus, streams a frame of pixels from src_* to
// img_*, counts datapath results and declares end of frame once the result
// strobe has been silent for DRAIN_CYCLES consecutive cycles.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : filter_ctrl_if.slave (host, cfg, src, img and result signals)
module filter_ctrl #(
  parameter int unsigned CFG_DWIDTH   = 32,
  parameter int unsigned CFG_AWIDTH   = 5,
  parameter int unsigned IMG_WIDTH    = 16,
  parameter int unsigned KER_WIDTH    = 16,
  parameter int unsigned KER_NB       = 9,
  parameter int unsigned LEN_WIDTH    = 24,
  parameter int unsigned DRAIN_CYCLES = 32
) (
  input logic          clk,
  input logic          rst,
  filter_ctrl_if.slave bus
);

  localparam int unsigned LOAD_WORDS = KER_NB + 2;
  localparam int unsigned LIDX_W     = $clog2(LOAD_WORDS);
  localparam int unsigned IDLE_W     = $clog2(DRAIN_CYCLES + 1);

  localparam logic [3:0] A_WIDTH   = 4'd0;
  localparam logic [3:0] A_RESCALE = 4'd1;
  localparam logic [3:0] A_KER0    = 4'd2;
  localparam logic [3:0] A_LEN     = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // shadow registers
  logic [15:0]          r_width;
  logic [15:0]          r_rescale;
  logic [KER_WIDTH-1:0] r_ker [KER_NB];
  logic [LEN_WIDTH-1:0] r_len;

  logic [LIDX_W-1:0]    r_load_idx;
  logic [LEN_WIDTH-1:0] r_pix_cnt;
  logic [LEN_WIDTH-1:0] r_res_cnt;
  logic [IDLE_W-1:0]    r_idle_cnt;
  logic [IMG_WIDTH-1:0] r_img_data;
  logic                 r_img_val;

  logic                  w_src_rdy;
  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_pix_nxt;
  logic                  w_cfg_valid;
  logic [CFG_AWIDTH-1:0] w_cfg_addr;
  logic [CFG_DWIDTH-1:0] w_cfg_data;
  logic                  w_done;

  // Ready is withheld once the frame length is reached, which also covers a
  // zero-length frame (ready never rises during its single STREAM cycle).
  assign w_src_rdy = (r_state == S_STREAM) && (r_pix_cnt != r_len);
  assign w_accept  = bus.src_val && w_src_rdy;
  assign w_pix_nxt = r_pix_cnt + LEN_WIDTH'(w_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_valid = 1'b0;
    w_cfg_addr  = '0;
    w_cfg_data  = '0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.host_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cfg_valid = 1'b1;
        if (r_load_idx == '0) begin
          w_cfg_addr = CFG_AWIDTH'(1);
          w_cfg_data = CFG_DWIDTH'(r_width);
        end else if (r_load_idx == LIDX_W'(LOAD_WORDS - 1)) begin
          w_cfg_addr  = CFG_AWIDTH'(3);
          w_cfg_data  = CFG_DWIDTH'(r_rescale);
          w_state_nxt = S_STREAM;
        end else begin
          w_cfg_addr = CFG_AWIDTH'(2);
          w_cfg_data = CFG_DWIDTH'(r_ker[r_load_idx - LIDX_W'(1)]);
        end
      end
      S_STREAM: begin
        if (w_pix_nxt == r_len) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // done fires in the last DRAIN cycle, so a start seen alongside it
        // falls on a non-IDLE state and is dropped.
        if (!bus.res_val && (r_idle_cnt == IDLE_W'(DRAIN_CYCLES - 1))) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shadow registers: writable only while idle; a write coinciding with
  // host_start lands before the first LOAD cycle reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width   <= '0;
      r_rescale <= '0;
      r_len     <= '0;
      for (int unsigned k = 0; k < KER_NB; k++) begin
        r_ker[k] <= '0;
      end
    end else if ((r_state == S_IDLE) && bus.host_wr) begin
      if (bus.host_addr == A_WIDTH) begin
        r_width <= bus.host_data[15:0];
      end
      if (bus.host_addr == A_RESCALE) begin
        r_rescale <= bus.host_data[15:0];
      end
      if (bus.host_addr == A_LEN) begin
        r_len <= bus.host_data[LEN_WIDTH-1:0];
      end
      for (int unsigned k = 0; k < KER_NB; k++) begin
        if (bus.host_addr == A_KER0 + 4'(k)) begin
          r_ker[k] <= bus.host_data[KER_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_idx <= '0;
      r_pix_cnt  <= '0;
      r_res_cnt  <= '0;
      r_idle_cnt <= '0;
      r_img_data <= '0;
      r_img_val  <= 1'b0;
    end else begin
      r_img_val <= w_accept;
      if (w_accept) begin
        r_img_data <= bus.src_data;
      end
      r_load_idx <= (r_state == S_LOAD) ? r_load_idx + 1'b1 : '0;
      r_idle_cnt <= ((r_state == S_DRAIN) && !bus.res_val) ? r_idle_cnt + 1'b1 : '0;
      if ((r_state == S_IDLE) && bus.host_start) begin
        r_pix_cnt <= '0;
        r_res_cnt <= '0;
      end else begin
        if (w_accept) begin
          r_pix_cnt <= w_pix_nxt;
        end
        if (((r_state == S_STREAM) || (r_state == S_DRAIN)) && bus.res_val &&
            (r_res_cnt != '1)) begin
          r_res_cnt <= r_res_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = w_done;
  assign bus.cfg_valid = w_cfg_valid;
  assign bus.cfg_addr  = w_cfg_addr;
  assign bus.cfg_data  = w_cfg_data;
  assign bus.src_rdy   = w_src_rdy;
  assign bus.img_data  = r_img_data;
  assign bus.img_val   = r_img_val;
  assign bus.res_cnt   = r_res_cnt;

endmodule

// File: tb/tb_filter_ctrl.sv
module tb_filter_ctrl;
  localparam int unsigned CFG_DWIDTH   = 32;
  localparam int unsigned CFG_AWIDTH   = 5;
  localparam int unsigned IMG_WIDTH    = 16;
  localparam int unsigned KER_WIDTH    = 16;
  localparam int unsigned KER_NB       = 9;
  localparam int unsigned LEN_WIDTH    = 24;
  localparam int unsigned DRAIN_CYCLES = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_ctrl_if #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH),
    .IMG_WIDTH(IMG_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  filter_ctrl #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .IMG_WIDTH(IMG_WIDTH),
    .KER_WIDTH(KER_WIDTH), .KER_NB(KER_NB), .LEN_WIDTH(LEN_WIDTH),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [CFG_AWIDTH-1:0] addr;
    logic [CFG_DWIDTH-1:0] data;
  } cfg_t;

  cfg_t                 q_cfg[$];
  logic [IMG_WIDTH-1:0] q_img[$];
  logic [31:0]          sh[16];
  int                   res_model;
  int                   n_cmp = 0;
  int                   n_bad = 0;
  bit                   mon_en = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: pops expected config words and pixels whenever the DUT presents them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cfg_valid === 1'b1) begin
        if (q_cfg.size() == 0) begin
          check("cfg_unexpected", 64'(bus.cfg_addr), 64'h0);
        end else begin
          cfg_t e;
          e = q_cfg.pop_front();
          check("cfg_addr", 64'(bus.cfg_addr), 64'(e.addr));
          check("cfg_data", 64'(bus.cfg_data), 64'(e.data));
        end
      end else begin
        check("cfg_quiet", 64'({bus.cfg_addr, bus.cfg_data}), 64'h0);
      end
      if (bus.img_val === 1'b1) begin
        if (q_img.size() == 0) begin
          check("img_unexpected", 64'(bus.img_data), 64'hDEAD);
        end else begin
          logic [IMG_WIDTH-1:0] p;
          p = q_img.pop_front();
          check("img_data", 64'(bus.img_data), 64'(p));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic st, input logic sv, input logic [15:0] sd, input logic rv);
    bus.host_wr    = wr;
    bus.host_addr  = a;
    bus.host_data  = d;
    bus.host_start = st;
    bus.src_val    = sv;
    bus.src_data   = sd;
    bus.res_val    = rv;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    drive(1'b1, a, d, 1'b0, 1'b0, 16'h0, 1'b0);
    sh[a] = d;
    @(negedge clk);
    check("busy_idle_wr", 64'(bus.busy), 64'h0);
  endtask

  task automatic push_cfg();
    cfg_t e;
    e.addr = CFG_AWIDTH'(1); e.data = 32'(sh[0][15:0]); q_cfg.push_back(e);
    for (int k = 0; k < KER_NB; k++) begin
      e.addr = CFG_AWIDTH'(2); e.data = 32'(sh[2+k][KER_WIDTH-1:0]); q_cfg.push_back(e);
    end
    e.addr = CFG_AWIDTH'(3); e.data = 32'(sh[1][15:0]); q_cfg.push_back(e);
  endtask

  task automatic run_frame(input bit directed, input bit allow_wr);
    logic       wr;
    logic [3:0] a;
    logic [31:0] d;
    logic       sv;
    logic [15:0] sd;
    logic       rv;
    int         len;
    int         acc;
    int         cyc;
    int         idle;
    int         pulses;
    int         gap;
    int         w;
    bit         exp_rdy;
    bit         exp_done;
    bit         finished;

    // IDLE start cycle, optionally with a same-cycle shadow write
    wr = allow_wr && !directed && ($urandom_range(0, 1) == 1);
    a  = 4'($urandom_range(0, 14));
    if (a == 4'd11) a = 4'd15;
    d  = $urandom;
    @(posedge clk); #1;
    drive(wr, a, d, 1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
    @(negedge clk);
    check("busy_start", 64'(bus.busy), 64'h0);
    check("res_cnt_hold", 64'(bus.res_cnt), 64'(res_model));
    if (wr) sh[a] = d;
    push_cfg();
    res_model = 0;
    len = int'(sh[11][LEN_WIDTH-1:0]);

    // LOAD: writes and starts must be dropped
    for (int i = 0; i < KER_NB + 2; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 1)), 4'd2, 32'h55, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("load_busy", 64'(bus.busy), 64'h1);
      check("load_cfg_valid", 64'(bus.cfg_valid), 64'h1);
      check("load_src_rdy", 64'(bus.src_rdy), 64'h0);
      check("load_res_cnt", 64'(bus.res_cnt), 64'h0);
    end

    // STREAM
    acc = 0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 400) begin
      exp_rdy = (acc < len);
      sv = directed ? (cyc % 2 == 0) : (($urandom_range(0, 1) == 1) || cyc > 40);
      sd = directed ? 16'(16'hA + acc) : 16'($urandom);
      rv = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      if (cyc == 1) drive(1'b1, 4'd2, 32'h55, 1'b1, sv, sd, rv);
      else          drive(1'b0, 4'd0, 32'h0, 1'b0, sv, sd, rv);
      @(negedge clk);
      check("stream_src_rdy", 64'(bus.src_rdy), 64'(exp_rdy));
      check("stream_busy", 64'(bus.busy), 64'h1);
      check("stream_res_cnt", 64'(bus.res_cnt), 64'(res_model));
      if (sv && exp_rdy) begin
        q_img.push_back(sd);
        acc++;
      end
      if (rv) res_model++;
      if (acc >= len) finished = 1'b1;
      cyc++;
    end
    check("stream_budget", 64'(finished), 64'h1);

    // DRAIN
    idle = 0;
    pulses = directed ? 3 : $urandom_range(0, 4);
    gap = directed ? 10 : $urandom_range(1, 31);
    w = 0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 400) begin
      rv = (pulses > 0) && (w == gap);
      if (rv) begin
        pulses--;
        w = 0;
        gap = directed ? 10 : $urandom_range(1, 31);
      end else begin
        w++;
      end
      exp_done = !rv && (idle + 1 == DRAIN_CYCLES);
      sv = directed ? 1'b1 : 1'($urandom_range(0, 1));
      sd = directed ? 16'(16'hA + acc) : 16'($urandom);
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h0, exp_done, sv, sd, rv);
      @(negedge clk);
      check("drain_done", 64'(bus.done), 64'(exp_done));
      check("drain_src_rdy", 64'(bus.src_rdy), 64'h0);
      check("drain_busy", 64'(bus.busy), 64'h1);
      check("drain_res_cnt", 64'(bus.res_cnt), 64'(res_model));
      if (rv) begin
        res_model++;
        idle = 0;
      end else begin
        idle++;
      end
      if (exp_done) finished = 1'b1;
      cyc++;
    end
    check("drain_budget", 64'(finished), 64'h1);

    // back in IDLE; start seen with done must not have launched a frame
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("post_busy", 64'(bus.busy), 64'h0);
      check("post_done", 64'(bus.done), 64'h0);
      check("post_res_cnt", 64'(bus.res_cnt), 64'(res_model));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_cfg", 64'({bus.cfg_valid, bus.cfg_addr, bus.cfg_data}), 64'h0);
    check("rst_src_rdy", 64'(bus.src_rdy), 64'h0);
    check("rst_img", 64'({bus.img_val, bus.img_data}), 64'h0);
    check("rst_res_cnt", 64'(bus.res_cnt), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) sh[i] = 32'h0;
    res_model = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // directed frame: width 64, kernel 1..9, rescale 0x0408, length 4
    host_write(4'd0, 32'd64);
    for (int k = 0; k < KER_NB; k++) host_write(4'(2 + k), 32'(k + 1));
    host_write(4'd1, 32'h0408);
    host_write(4'd11, 32'd4);
    run_frame(1'b1, 1'b0);
    check("directed_res_cnt", 64'(bus.res_cnt), 64'd3);

    // frame with length 0, shadows otherwise unchanged
    host_write(4'd11, 32'd0);
    run_frame(1'b1, 1'b0);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) begin
        host_write(4'(i), (i == 11) ? 32'($urandom_range(0, 12)) : $urandom);
      end
      run_frame(1'b0, 1'b1);
    end

    // reset in the middle of LOAD, after the 5th config write
    host_write(4'd11, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    push_cfg();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      if (i == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q_cfg.delete();
    for (int i = 0; i < 16; i++) sh[i] = 32'h0;
    res_model = 0;
    @(negedge clk);
    check_reset_vals();
    run_frame(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("cfg_queue_empty", 64'(q_cfg.size()), 64'h0);
    check("img_queue_empty", 64'(q_img.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameters: CFG_DWIDTH=32 cfg word width; CFG_AWIDTH=5 cfg address width; IMG_WIDTH=16 pixel width; KER_WIDTH=16 coefficient width; KER_NB=9 coefficients per kernel; LEN_WIDTH=24 frame pixel-count width; DRAIN_CYCLES=32 idle cycles that mark end of frame.
REQ-002 Ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 host_wr in 1 shadow-register write strobe; host_addr in 4 shadow index; host_data in CFG_DWIDTH write data.
REQ-004 host_start in 1 start-frame pulse; busy out 1 sequence in progress; done out 1 one-cycle end-of-frame pulse.
REQ-005 cfg_data out CFG_DWIDTH, cfg_addr out CFG_AWIDTH, cfg_valid out 1: config bus to filter datapath.
REQ-006 src_data in IMG_WIDTH, src_val in 1, src_rdy out 1: upstream pixel stream, valid/ready.
REQ-007 img_data out IMG_WIDTH, img_val out 1: pixel stream to filter datapath; res_val in 1: datapath result strobe.
REQ-008 res_cnt out LEN_WIDTH: results counted in current/last frame.

Function
REQ-009 Shadow map: addr 0 line width (bits [15:0]); 1 rescale word (shift [15:8], head [7:0]); 2..10 kernel coefficients 0..8 (bits [KER_WIDTH-1:0]); 11 frame length (bits [LEN_WIDTH-1:0]); addrs 12..15 ignored.
REQ-010 host_wr accepted only in IDLE; writes while busy=1 dropped, shadows unchanged.
REQ-011 FSM states IDLE, LOAD, STREAM, DRAIN; busy=1 in every state except IDLE.
REQ-012 IDLE->LOAD on host_start=1; host_start outside IDLE ignored.
REQ-013 LOAD: 11 consecutive cycles cfg_valid=1, order: addr 1 (width), addr 2 x9 (kernel 0..8 ascending), addr 3 (rescale); cfg_data zero-extended shadow value; no gaps.
REQ-014 cfg_valid=0 and cfg_data=0, cfg_addr=0 in all cycles outside LOAD.
REQ-015 LOAD->STREAM on cycle after 11th write; pixel counter and res_cnt cleared on entry to LOAD.
REQ-016 STREAM: src_rdy=1; each src_val&src_rdy cycle registers src_data to img_data with img_val=1 next cycle (latency 1); img_val=0 otherwise.
REQ-017 STREAM->DRAIN when accepted pixel count reaches frame length; src_rdy drops in the cycle after the last accept (no extra pixel accepted).
REQ-018 Frame length 0: STREAM lasts one cycle with src_rdy=0, goes straight to DRAIN.
REQ-019 res_cnt increments on every res_val=1 in STREAM or DRAIN; saturates at all-ones; holds value in IDLE.
REQ-020 DRAIN: idle counter counts consecutive cycles with res_val=0, reset to 0 by any res_val=1; at DRAIN_CYCLES -> IDLE with done=1 for one cycle.
REQ-021 host_start coincident with done cycle ignored (FSM not yet in IDLE).
REQ-022 host_wr and host_start same cycle in IDLE: write takes effect; LOAD uses new value.

Reset
REQ-023 rst=1: FSM to IDLE; busy, done, cfg_valid, src_rdy, img_val = 0; cfg_data, cfg_addr, img_data, res_cnt = 0; all shadows = 0.
REQ-024 rst mid-LOAD/STREAM/DRAIN aborts immediately, same values as REQ-023; no done pulse.

Verification
REQ-025 Write width=64, kernel 1..9, rescale 0x0408, len=4, start -> 11 cfg writes: (1,64),(2,1)..(2,9),(3,0x0408), consecutive, then src_rdy=1.
REQ-026 STREAM, src_val toggling, pixels 0xA,0xB,0xC,0xD,0xE -> img_data 0xA..0xD each 1 cycle after accept; 0xE not accepted; src_rdy=0 after 4th.
REQ-027 DRAIN with res_val pulses at gaps of 10 cycles x3 then silence -> res_cnt=3, done exactly 32 cycles after last res_val.
REQ-028 host_wr addr 2 data 0x55 and host_start during STREAM -> ignored; next frame loads original kernel 0.
REQ-029 len=0, start -> 11 cfg writes, no pixel accepted, done after 32 idle cycles.
REQ-030 rst asserted in LOAD after 5th write -> next cycle cfg_valid=0, busy=0, shadows 0; following start emits all-zero config.
